// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator package: divider FSM encoding and default operand width
package calc_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/sub_nbits.sv
// rtl/sub_nbits.sv - unsigned n-bit subtractor, d = a - b, cout high when no borrow
module sub_nbits #(
  parameter int width = 8
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] d_o,
  output logic             cout_o
);

  assign {cout_o, d_o} = {1'b0, a_i} + {1'b0, ~b_i} + (width+1)'(1);

endmodule

// File: rtl/div_nbits.sv
// rtl/div_nbits.sv - sequential restoring divider, one quotient bit per clock
module div_nbits
  import calc_pkg::*;
#(
  parameter int width = DIV_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [width-1:0] q_o,
  output logic [width-1:0] r_o,
  output logic             dbz_o
);

  localparam int CW = $clog2(width) + 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [width-1:0] rem;
  logic [width-1:0] quo;
  logic [width-1:0] dvsr;
  logic             dbz_pend;

  logic [width:0]   rem_shift;
  logic [width:0]   trial;
  logic             unused_cout;
  logic [width-1:0] next_rem;
  logic [width-1:0] next_quo;

  // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  assign rem_shift = {rem, quo[width-1]};

  sub_nbits #(.width(width + 1)) u_trial (
    .a_i    (rem_shift),
    .b_i    ({1'b0, dvsr}),
    .d_o    (trial),
    .cout_o (unused_cout)
  );

  assign next_rem = trial[width] ? rem_shift[width-1:0] : trial[width-1:0];
  assign next_quo = {quo[width-2:0], ~trial[width]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      q_o      <= '0;
      r_o      <= '0;
      dbz_o    <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      dbz_pend <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            quo      <= a_i;
            dvsr     <= b_i;
            rem      <= '0;
            cnt      <= '0;
            dbz_pend <= (b_i == '0);
            busy_o   <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // A zero divisor spends its single latency cycle here without stepping.
          if (dbz_pend) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            q_o    <= '1;
            r_o    <= quo;
            dbz_o  <= 1'b1;
          end else begin
            rem <= next_rem;
            quo <= next_quo;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              q_o    <= next_quo;
              r_o    <= next_rem;
              dbz_o  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_nbits.sv
// tb/tb_div_nbits.sv - self-checking bench for div_nbits with directed and random divisions
module tb_div_nbits;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b, q, r;
  logic         busy, done, dbz;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;
  logic         prev_dbz = 1'b0;

  div_nbits #(.width(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .q_o     (q),
    .r_o     (r),
    .dbz_o   (dbz)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at the sample point after the accept edge; lat counts edges since accept.
  task automatic wait_done(input int lat0, output int lat, output int busy_hi);
    lat = lat0;
    busy_hi = busy ? 1 : 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) return;
      busy_hi += busy ? 1 : 0;
      if (lat == 4) begin
        check_eq("hold q", q, prev_q);
        check_eq("hold r", r, prev_r);
        check_eq("hold dbz", dbz, prev_dbz);
      end
    end
    lat = -1;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed);
    check_eq({tag, " q"}, q, eq);
    check_eq({tag, " r"}, r, er);
    check_eq({tag, " dbz"}, dbz, ed);
    check_eq({tag, " busy at done"}, busy, 0);
    if (bv != 0) begin
      check_eq({tag, " a=q*b+r"}, 32'(q) * 32'(bv) + 32'(r), 32'(av));
      check_eq({tag, " r<b"}, 32'(r < bv), 1);
    end
    prev_q = eq;
    prev_r = er;
    prev_dbz = ed;
  endtask

  // Caller sits at a negedge; issues one start pulse and checks the whole division.
  task automatic do_div(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] eq, er;
    logic         ed;
    int           el, lat, bh;
    string        tag;
    tag = $sformatf("%0d/%0d", av, bv);
    if (bv == 0) begin
      eq = '1; er = av; ed = 1'b1; el = 1;
    end else begin
      eq = av / bv; er = av % bv; ed = 1'b0; el = W;
    end
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, lat, bh);
    check_eq({tag, " latency"}, lat, el);
    check_eq({tag, " busy cycles"}, bh, el);
    check_result(tag, av, bv, eq, er, ed);
    @(negedge clk);
    check_eq({tag, " done drop"}, done, 0);
  endtask

  initial begin
    int lat, bh, saw;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #3;
    check_eq("reset busy", busy, 0);
    check_eq("reset done", done, 0);
    check_eq("reset q", q, 0);
    check_eq("reset r", r, 0);
    check_eq("reset dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_div(8'd100, 8'd7);
    do_div(8'd255, 8'd1);
    do_div(8'd5, 8'd9);
    do_div(8'd0, 8'd3);
    do_div(8'd37, 8'd0);
    do_div(8'd9, 8'd3);

    // start during RUN is ignored, start during DONE is taken back-to-back
    a = 8'd100; b = 8'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'd50; b = 8'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(3, lat, bh);
    check_eq("b2b first latency", lat, 8);
    check_result("b2b first", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    a = 8'd50; b = 8'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("b2b done drop", done, 0);
    check_eq("b2b busy", busy, 1);
    wait_done(0, lat, bh);
    check_eq("b2b second latency", lat, 8);
    check_result("b2b second", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0);
    @(negedge clk);

    // reset in the middle of a division
    a = 8'd200; b = 8'd16; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrun reset busy", busy, 0);
    check_eq("midrun reset done", done, 0);
    check_eq("midrun reset q", q, 0);
    check_eq("midrun reset r", r, 0);
    check_eq("midrun reset dbz", dbz, 0);
    saw = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) saw++;
    end
    check_eq("no done while reset", saw, 0);
    prev_q = '0; prev_r = '0; prev_dbz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_div(8'd200, 8'd16);

    for (int i = 0; i < 1000; i++)
      do_div(W'($urandom_range(0, 255)), W'($urandom_range(1, 255)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
